instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the MiniSRC control unit. Issues word reads at the fetch PC to

---
 rtl/minisrc_pkg.sv | 12 +
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 93 +++++++++
 tb/tb_instr_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/minisrc_pkg.sv
// Shared MiniSRC constants and types used by the fetch stage and its bench.
package minisrc_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned DEF_ADDR_W   = 9;
  localparam int unsigned DEF_DEPTH    = 2;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
  localparam logic [WORD_W-1:0]     NOP_WORD     = '0;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus control-unit handshake.
interface instr_fetch_unit_if import minisrc_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              fetch_en;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_data;
  logic              mem_ready;
  word_t             ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ack;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    input  fetch_en, mem_data, mem_ready, ir_ack, redirect, redirect_pc,
    output mem_rd, mem_addr, ir, ir_pc, ir_valid
  );

  modport slave (
    output fetch_en, mem_data, mem_ready, ir_ack, redirect, redirect_pc,
    input  mem_rd, mem_addr, ir, ir_pc, ir_valid
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, word} pairs with flush; head is NOP/0 while empty.
module fetch_fifo import minisrc_pkg::*; #(
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  word_t             word_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output word_t             head_word_o,
  output logic              valid_o
);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  word_t             word_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             pop_eff;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_eff  = pop_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_i, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !flush_i) begin
      pc_mem[wr_ptr_q]   <= pc_i;
      word_mem[wr_ptr_q] <= word_i;
    end
  end

  assign count_o     = count_q;
  assign valid_o     = (count_q != '0);
  assign head_pc_o   = valid_o ? pc_mem[rd_ptr_q]   : '0;
  assign head_word_o = valid_o ? word_mem[rd_ptr_q] : NOP_WORD;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word read at a time, prefetch buffering, redirect flush/drop.
module instr_fetch_unit import minisrc_pkg::*; #(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input logic                clock,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q,   mem_rd_d;
  logic              drop_q,     drop_d;

  logic              complete;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] head_pc;
  word_t             head_word;
  logic              head_valid;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_rd_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      drop_q     <= drop_d;
    end
  end

  // mem_rd_q doubles as the outstanding flag; a stray mem_ready without it is ignored.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    drop_d     = drop_q;
    complete   = mem_rd_q && bus.mem_ready;
    issue      = bus.fetch_en && !mem_rd_q && !bus.redirect &&
                 (fifo_count < CNT_W'(DEPTH));
    push       = complete && !drop_q && !bus.redirect;
    pop        = bus.ir_ack && !bus.redirect;

    if (complete) begin
      mem_rd_d = 1'b0;
      drop_d   = 1'b0;
    end
    if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    if (issue) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = fetch_pc_q;
    end
    // Redirect wins; a request still in flight is marked so its data is discarded.
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      if (mem_rd_q && !bus.mem_ready) drop_d = 1'b1;
    end
  end

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .rst         (rst),
    .push_i      (push),
    .pc_i        (fetch_pc_q),
    .word_i      (bus.mem_data),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .count_o     (fifo_count),
    .head_pc_o   (head_pc),
    .head_word_o (head_word),
    .valid_o     (head_valid)
  );

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ir       = head_word;
  assign bus.ir_pc    = head_pc;
  assign bus.ir_valid = head_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fill, streaming, redirects, PC wrap, reset mid-request.
module tb_instr_fetch_unit;
  import minisrc_pkg::*;

  localparam int unsigned AW = DEF_ADDR_W;

  logic clock;
  logic rst;

  instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (AW),
    .DEPTH    (2),
    .RESET_PC (9'h000)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks;
  int n_fail;
  bit auto_mem;
  int lat;
  int wait_cnt;
  logic [AW-1:0] served[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory word for address a is 32'hC0DE_0000 | a.
  task automatic step();
    @(negedge clock);
    if (auto_mem) begin
      if (bus.mem_rd && wait_cnt >= lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'hC0DE_0000 | {23'h0, bus.mem_addr};
        served.push_back(bus.mem_addr);
        wait_cnt = 0;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_data  = 32'hDEAD_BEEF;
        if (bus.mem_rd) wait_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.fetch_en    = 1'b0;
    bus.ir_ack      = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_data    = '0;
    auto_mem        = 1'b0;
    lat             = 0;
    wait_cnt        = 0;
    served.delete();
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    bus.fetch_en = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %0h expected 0", bus.mem_rd); end
    n_checks++; if (bus.mem_addr !== 9'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr); end
    n_checks++; if (bus.ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %0h expected 0", bus.ir); end
    n_checks++; if (bus.ir_pc !== 9'h000) begin n_fail++; $display("FAIL reset_ir_pc: got %0h expected 0", bus.ir_pc); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %0h expected 0", bus.ir_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    auto_mem = 1'b1;
    lat = 0;
    bus.fetch_en = 1'b1;
    step();
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid_early: got %0h expected 0", bus.ir_valid); end
    step();
    n_checks++; if (bus.ir_valid !== 1'b1) begin n_fail++; $display("FAIL fill_latency: got %0h expected 1", bus.ir_valid); end
    repeat (6) step();
    n_checks++; if (served.size() !== 2) begin n_fail++; $display("FAIL fill_req_count: got %0d expected 2", served.size()); end
    n_checks++; if (served.size() < 1 || served[0] !== 9'h000) begin n_fail++; $display("FAIL fill_addr0: expected 0 (requests %0d)", served.size()); end
    n_checks++; if (served.size() < 2 || served[1] !== 9'h001) begin n_fail++; $display("FAIL fill_addr1: expected 1 (requests %0d)", served.size()); end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL fill_mem_rd_idle: got %0h expected 0", bus.mem_rd); end
    n_checks++; if (bus.ir !== 32'hC0DE_0000) begin n_fail++; $display("FAIL fill_ir: got %0h expected c0de0000", bus.ir); end
    n_checks++; if (bus.ir_pc !== 9'h000) begin n_fail++; $display("FAIL fill_ir_pc: got %0h expected 0", bus.ir_pc); end
  endtask

  task automatic test_stream();
    logic [AW-1:0] seen[$];
    int  dup;
    bit  prev;
    do_reset();
    auto_mem = 1'b1;
    lat = 3;
    bus.fetch_en = 1'b1;
    bus.ir_ack = 1'b1;
    dup = 0;
    prev = 1'b0;
    repeat (30) begin
      step();
      if (bus.ir_valid) begin
        seen.push_back(bus.ir_pc);
        if (prev) dup++;
      end
      prev = bus.ir_valid;
    end
    n_checks++; if (seen.size() !== 6) begin n_fail++; $display("FAIL stream_count: got %0d expected 6", seen.size()); end
    n_checks++; if (dup !== 0) begin n_fail++; $display("FAIL stream_gap: got %0d back-to-back valids expected 0", dup); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (seen.size() <= i || seen[i] !== AW'(i)) begin
        n_fail++; $display("FAIL stream_pc%0d: expected %0h (entries %0d)", i, i, seen.size());
      end
    end
  endtask

  task automatic test_redirect_pending();
    logic [AW-1:0] first_addr;
    bit got_addr;
    bit got_valid;
    do_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h005;
    step();
    bus.redirect = 1'b0;
    bus.fetch_en = 1'b1;
    step();
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h005) begin n_fail++; $display("FAIL redir_req5: got rd=%0h addr=%0h expected rd=1 addr=5", bus.mem_rd, bus.mem_addr); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h040;
    step();
    bus.redirect = 1'b0;
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h005) begin n_fail++; $display("FAIL redir_hold: got rd=%0h addr=%0h expected rd=1 addr=5", bus.mem_rd, bus.mem_addr); end
    step();
    bus.mem_ready = 1'b1;
    bus.mem_data = 32'hC0DE_0005;
    step();
    bus.mem_ready = 1'b0;
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop: got ir_valid=%0h expected 0", bus.ir_valid); end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL redir_drop_rd: got %0h expected 0", bus.mem_rd); end
    auto_mem = 1'b1;
    wait_cnt = 0;
    got_addr = 1'b0;
    got_valid = 1'b0;
    first_addr = '0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      step();
      if (bus.mem_rd && !got_addr) begin first_addr = bus.mem_addr; got_addr = 1'b1; end
      if (bus.ir_valid) got_valid = 1'b1;
    end
    n_checks++; if (first_addr !== 9'h040) begin n_fail++; $display("FAIL redir_next_addr: got %0h expected 40", first_addr); end
    n_checks++; if (got_valid !== 1'b1) begin n_fail++; $display("FAIL redir_timeout: ir_valid never rose, expected 1"); end
    n_checks++; if (bus.ir_pc !== 9'h040) begin n_fail++; $display("FAIL redir_ir_pc: got %0h expected 40", bus.ir_pc); end
    n_checks++; if (bus.ir !== 32'hC0DE_0040) begin n_fail++; $display("FAIL redir_ir: got %0h expected c0de0040", bus.ir); end
  endtask

  task automatic test_redirect_collision();
    logic [AW-1:0] first_addr;
    bit got_addr;
    bit got_valid;
    do_reset();
    bus.fetch_en = 1'b1;
    step();
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h000) begin n_fail++; $display("FAIL coll_req0: got rd=%0h addr=%0h expected rd=1 addr=0", bus.mem_rd, bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_data = 32'hC0DE_0000;
    step();
    bus.mem_ready = 1'b0;
    n_checks++; if (bus.ir_valid !== 1'b1) begin n_fail++; $display("FAIL coll_entry0: got ir_valid=%0h expected 1", bus.ir_valid); end
    step();
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h001) begin n_fail++; $display("FAIL coll_req1: got rd=%0h addr=%0h expected rd=1 addr=1", bus.mem_rd, bus.mem_addr); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h123;
    bus.ir_ack = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_data = 32'hC0DE_0001;
    step();
    bus.redirect = 1'b0;
    bus.ir_ack = 1'b0;
    bus.mem_ready = 1'b0;
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL coll_flush_valid: got %0h expected 0", bus.ir_valid); end
    n_checks++; if (bus.ir !== 32'h0 || bus.ir_pc !== 9'h000) begin n_fail++; $display("FAIL coll_flush_head: got ir=%0h pc=%0h expected 0/0", bus.ir, bus.ir_pc); end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL coll_rd: got %0h expected 0", bus.mem_rd); end
    auto_mem = 1'b1;
    wait_cnt = 0;
    got_addr = 1'b0;
    got_valid = 1'b0;
    first_addr = '0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      step();
      if (bus.mem_rd && !got_addr) begin first_addr = bus.mem_addr; got_addr = 1'b1; end
      if (bus.ir_valid) got_valid = 1'b1;
    end
    n_checks++; if (first_addr !== 9'h123) begin n_fail++; $display("FAIL coll_next_addr: got %0h expected 123", first_addr); end
    n_checks++; if (got_valid !== 1'b1 || bus.ir_pc !== 9'h123) begin n_fail++; $display("FAIL coll_ir_pc: got valid=%0h pc=%0h expected 1/123", got_valid, bus.ir_pc); end
    n_checks++; if (bus.ir !== 32'hC0DE_0123) begin n_fail++; $display("FAIL coll_ir: got %0h expected c0de0123", bus.ir); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] seen[$];
    do_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h1FF;
    step();
    bus.redirect = 1'b0;
    bus.fetch_en = 1'b1;
    bus.ir_ack = 1'b1;
    auto_mem = 1'b1;
    lat = 0;
    repeat (12) begin
      step();
      if (bus.ir_valid) seen.push_back(bus.ir_pc);
    end
    n_checks++; if (served.size() < 1 || served[0] !== 9'h1FF) begin n_fail++; $display("FAIL wrap_addr_1ff: expected 1ff (requests %0d)", served.size()); end
    n_checks++; if (served.size() < 2 || served[1] !== 9'h000) begin n_fail++; $display("FAIL wrap_addr_000: expected 0 (requests %0d)", served.size()); end
    n_checks++; if (seen.size() < 1 || seen[0] !== 9'h1FF) begin n_fail++; $display("FAIL wrap_ir_pc_1ff: expected 1ff (entries %0d)", seen.size()); end
    n_checks++; if (seen.size() < 2 || seen[1] !== 9'h000) begin n_fail++; $display("FAIL wrap_ir_pc_000: expected 0 (entries %0d)", seen.size()); end
  endtask

  task automatic test_reset_midreq();
    do_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h077;
    step();
    bus.redirect = 1'b0;
    bus.fetch_en = 1'b1;
    step();
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h077) begin n_fail++; $display("FAIL rstmid_req: got rd=%0h addr=%0h expected rd=1 addr=77", bus.mem_rd, bus.mem_addr); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_async: got %0h expected 0", bus.mem_rd); end
    n_checks++; if (bus.mem_addr !== 9'h000) begin n_fail++; $display("FAIL rstmid_addr_async: got %0h expected 0", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_data = 32'hC0DE_0077;
    step();
    rst = 1'b0;
    step();
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got ir_valid=%0h expected 0", bus.ir_valid); end
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h000) begin n_fail++; $display("FAIL rstmid_first_req: got rd=%0h addr=%0h expected rd=1 addr=0", bus.mem_rd, bus.mem_addr); end
    bus.mem_data = 32'hC0DE_0000;
    step();
    bus.mem_ready = 1'b0;
    n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 9'h000) begin n_fail++; $display("FAIL rstmid_entry: got valid=%0h pc=%0h expected 1/0", bus.ir_valid, bus.ir_pc); end
    n_checks++; if (bus.ir !== 32'hC0DE_0000) begin n_fail++; $display("FAIL rstmid_ir: got %0h expected c0de0000", bus.ir); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset();
    test_fill();
    test_stream();
    test_redirect_pending();
    test_redirect_collision();
    test_wrap();
    test_reset_midreq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
